corefifo_wr_ptr_ctrl: RTL and testbench
=======================================

# corefifo_wr_ptr_ctrl

Write-side pointer and flag controller for the dual-clock FIFO, running entirely in the write clock domain. It accepts write requests, drives the RAM write strobe and address, and maintains the binary and Gray-coded write pointers. It publishes the registered Gray write pointer toward the read-domain synchronizer. It consumes the read Gray pointer already synchronized into this domain and derives full, almost-full, fill level and overflow.

## Interface
Parameters:
- ADDRWIDTH, 3: RAM address width; depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits; legal range 2..16.
- AFULL_THRESH, 6: fill level at or above which afull asserts; legal range 1..2^ADDRWIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  write-domain clock; all state updates on rising edge.
- srst  in  1  synchronous active-high reset.
- wr_en  in  1  write request from the producer.
- rd_gray_sync  in  ADDRWIDTH+1  read pointer (Gray), already synchronized into clk domain.
- wr_we  out  1  RAM write strobe; combinational, wr_en & ~full.
- wr_addr  out  ADDRWIDTH  RAM write address = wr_bin[ADDRWIDTH-1:0]; registered.
- wr_gray  out  ADDRWIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- full  out  1  registered; FIFO holds 2^ADDRWIDTH words.
- afull  out  1  registered; wr_count >= AFULL_THRESH.
- wr_count  out  ADDRWIDTH+1  registered fill level as seen from the write side.
- overflow  out  1  registered one-cycle pulse when wr_en is high while full.

## Operation
- Accept: accept = wr_en & ~full. wr_we mirrors accept in the same cycle, using the current wr_addr.
- Pointer: wr_bin_next = wr_bin + accept, modulo 2^(ADDRWIDTH+1). wr_bin <= wr_bin_next. wr_gray <= wr_bin_next ^ (wr_bin_next >> 1). Only wr_gray crosses domains, and only one bit of it changes per cycle.
- Read side: rd_bin = Gray-to-binary of rd_gray_sync. The conversion is combinational; the input is registered upstream.
- full <= (gray(wr_bin_next) == {~rd_gray_sync[ADDRWIDTH:ADDRWIDTH-1], rd_gray_sync[ADDRWIDTH-2:0]}).
- wr_count <= wr_bin_next - rd_bin, modulo 2^(ADDRWIDTH+1). This never exceeds 2^ADDRWIDTH.
- afull <= (wr_bin_next - rd_bin) >= AFULL_THRESH.
- overflow <= wr_en & full. On overflow, the pointer is unchanged and wr_we is 0.
- Flags are conservative. Reads seen through the synchronizer release full late, never early. full is never cleared by a write.
- No state machine. State consists of wr_bin, wr_gray, full, afull, wr_count and overflow.

## Timing
- Reset (srst high at a clk edge): wr_bin=0, wr_addr=0, wr_gray=0, full=0, afull=0, wr_count=0, overflow=0.
- During the srst cycle, wr_we is forced to 0 regardless of wr_en.
- Reset asserted mid-fill wins over a simultaneous write: the pending write is dropped.
- Write latency: an accepted write in cycle N updates wr_addr, wr_gray, wr_count and flags at edge N+1.
- full asserts at the edge that completes the 2^ADDRWIDTH-th outstanding write, so no second write is accepted.
- Read release: a change on rd_gray_sync in cycle N is reflected in full, afull and wr_count at edge N+1.
- Simultaneous write and rd_gray_sync advance in one cycle: both are applied in the same next-state computation, so the count is unchanged for a +1/+1 pair.
- Wrap: wr_bin 2^(ADDRWIDTH+1)-1 rolls to 0. For ADDRWIDTH=3, wr_gray goes 1000 -> 0000.

## Structure
- Shared package corefifo_ptr_pkg holds:
  - functions bin2gray and gray2bin, parameterized by width;
  - the pointer width constant PTRW = ADDRWIDTH+1, as a localparam pattern.
- The read-side controller (rd_ptr_ctrl) reuses the same package.
- One natural sub-module: corefifo_gray2bin, a combinational XOR-prefix converter of width ADDRWIDTH+1.

## Test plan
Defaults: ADDRWIDTH=3, AFULL_THRESH=6.
- Fill: srst, then 8 writes with rd_gray_sync=0000 -> full=1 the cycle after the 8th write; wr_gray=1100, wr_count=8, wr_addr=0.
- Overflow: 9th wr_en while full -> wr_we=0, overflow pulses once, wr_gray stays 1100.
- Release: with full set, drive rd_gray_sync=0010 (bin 3) -> next cycle full=0, wr_count=5, afull=0.
- Wrap: stream writes while the read pointer tracks 2 behind, through wr_bin 15 -> 0 -> wr_gray 1000 -> 0000, wr_count stays 2, full never asserts.
- Almost-full: from empty, 5 writes -> afull=0; 6th write -> afull=1 at the next edge.
- Reset mid-operation: srst with wr_en=1 at count 4 -> wr_we=0 that cycle; next cycle all outputs zero.

Source files
------------

// File: rtl/corefifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO controllers.
// Gray/binary conversions and pointer width derivation.
package corefifo_ptr_pkg;

    localparam int PTR_MAXW = 17;

    typedef logic [PTR_MAXW-1:0] ptr_max_t;

    function automatic int ptr_width(input int addrwidth);
        return addrwidth + 1;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = '0;
        for (int i = 0; i < PTR_MAXW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/corefifo_gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module corefifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // XOR-prefix from the MSB downward
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/corefifo_wr_ptr_ctrl.sv
// Write-side pointer and flag controller of the dual-clock FIFO.
// Owns the write pointer; derives full/afull/count from the synced read pointer.
module corefifo_wr_ptr_ctrl
    import corefifo_ptr_pkg::*;
#(
    parameter int ADDRWIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH:0]   rd_gray_sync,
    output logic                 wr_we,
    output logic [ADDRWIDTH-1:0] wr_addr,
    output logic [ADDRWIDTH:0]   wr_gray,
    output logic                 full,
    output logic                 afull,
    output logic [ADDRWIDTH:0]   wr_count,
    output logic                 overflow
);

    localparam int PTRW = ptr_width(ADDRWIDTH);

    logic [PTRW-1:0] wr_bin;
    logic [PTRW-1:0] wr_bin_next;
    logic [PTRW-1:0] gray_next;
    logic [PTRW-1:0] rd_bin;
    logic [PTRW-1:0] rd_gray_full;
    logic [PTRW-1:0] cnt_next;
    logic            accept;
    logic            full_next;
    logic            afull_next;

    corefifo_gray2bin #(
        .W(PTRW)
    ) u_rd_g2b (
        .gray(rd_gray_sync),
        .bin (rd_bin)
    );

    // A reset cycle never writes, so the dropped write leaves no RAM trace
    assign accept      = wr_en & ~full & ~srst;
    assign wr_we       = accept;
    assign wr_addr     = wr_bin[ADDRWIDTH-1:0];

    assign wr_bin_next = wr_bin + {{(PTRW-1){1'b0}}, accept};
    assign gray_next   = PTRW'(bin2gray(ptr_max_t'(wr_bin_next)));

    // Full when write is exactly one lap ahead: top two Gray bits inverted
    assign rd_gray_full = {~rd_gray_sync[ADDRWIDTH -: 2],
                           rd_gray_sync[ADDRWIDTH-2:0]};
    assign full_next    = (gray_next == rd_gray_full);

    assign cnt_next     = wr_bin_next - rd_bin;
    assign afull_next   = (32'(cnt_next) >= AFULL_THRESH);

    // Pointer and flag registers
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_bin   <= '0;
            wr_gray  <= '0;
            full     <= 1'b0;
            afull    <= 1'b0;
            wr_count <= '0;
            overflow <= 1'b0;
        end else begin
            wr_bin   <= wr_bin_next;
            wr_gray  <= gray_next;
            full     <= full_next;
            afull    <= afull_next;
            wr_count <= cnt_next;
            overflow <= wr_en & full;
        end
    end

endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl.sv
// Scoreboard bench for corefifo_wr_ptr_ctrl with default parameters.
// Reference model tracks total writes/reads as plain integers.
module tb_corefifo_wr_ptr_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int TH    = 6;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [3:0] gray;
        logic       full;
        logic       afull;
        logic [3:0] cnt;
        logic       ovf;
    } rec_t;

    logic       clk;
    logic       srst;
    logic       wr_en;
    logic [3:0] rd_gray_sync;
    logic       wr_we;
    logic [2:0] wr_addr;
    logic [3:0] wr_gray;
    logic       full;
    logic       afull;
    logic [3:0] wr_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    rec_t q[$];

    int  wr_tot = 0;
    int  rd_tot = 0;
    bit  m_full = 0;

    corefifo_wr_ptr_ctrl #(
        .ADDRWIDTH   (AW),
        .AFULL_THRESH(TH)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .wr_en       (wr_en),
        .rd_gray_sync(rd_gray_sync),
        .wr_we       (wr_we),
        .wr_addr     (wr_addr),
        .wr_gray     (wr_gray),
        .full        (full),
        .afull       (afull),
        .wr_count    (wr_count),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] to_gray(input int v);
        int b;
        b = v % 16;
        return 4'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs and push the model's prediction
    task automatic cyc(input bit rst, input bit w, input int rd_new);
        rec_t r;
        int   c;
        if (rst) rd_new = 0;
        srst         = rst;
        wr_en        = w;
        rd_gray_sync = to_gray(rd_new);
        if (rst) begin
            wr_tot  = 0;
            rd_tot  = 0;
            m_full  = 0;
            r.we    = 1'b0;
            r.addr  = '0;
            r.gray  = '0;
            r.full  = 1'b0;
            r.afull = 1'b0;
            r.cnt   = '0;
            r.ovf   = 1'b0;
        end else begin
            rd_tot  = rd_new;
            r.we    = w && !m_full;
            r.ovf   = w && m_full;
            wr_tot += int'(r.we);
            c       = wr_tot - rd_tot;
            r.addr  = 3'(wr_tot % DEPTH);
            r.gray  = to_gray(wr_tot);
            r.cnt   = 4'(c);
            r.full  = (c == DEPTH);
            r.afull = (c >= TH);
            m_full  = r.full;
        end
        q.push_back(r);
        @(posedge clk);
        #2;
    endtask

    // Monitor: strobe checked in its own cycle, registers one edge later
    rec_t pend;
    bit   pend_v = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (pend_v) begin
                chk("wr_addr",  32'(wr_addr),  32'(pend.addr));
                chk("wr_gray",  32'(wr_gray),  32'(pend.gray));
                chk("full",     32'(full),     32'(pend.full));
                chk("afull",    32'(afull),    32'(pend.afull));
                chk("wr_count", 32'(wr_count), 32'(pend.cnt));
                chk("overflow", 32'(overflow), 32'(pend.ovf));
                pend_v = 0;
            end
            if (q.size() > 0) begin
                pend   = q.pop_front();
                chk("wr_we", 32'(wr_we), 32'(pend.we));
                pend_v = 1;
            end
        end
    end

    initial begin
        int rn;
        srst         = 1'b1;
        wr_en        = 1'b0;
        rd_gray_sync = '0;

        cyc(1, 0, 0);
        cyc(1, 1, 0);

        // fill to full, then overflow, then release via read jump to 3
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 3);
        cyc(0, 0, 3);

        // wrap with reader tracking two behind
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, rd_tot + 1);
        cyc(0, 0, rd_tot);

        // almost-full threshold
        cyc(1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0);

        // reset mid-fill with a simultaneous write
        cyc(1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rn = rd_tot;
            if (rd_tot < wr_tot && ($urandom_range(0, 99) < 45))
                rn = rd_tot + 1;
            cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), rn);
        end
        cyc(0, 0, rd_tot);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0 || pend_v) begin
            fails++;
            $display("FAIL drain: %0d records left unchecked", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
